// File: rtl/sphere_closest_hit_scheduler.sv
// Walks the sphere table for one ray, issues each sphere to a hit unit and keeps the closest valid hit.
// Optional SPHERE_ANY_HIT_EN adds any_hit_mode: the first valid hit stops issue (shadow rays).
`ifndef PRIMITIVE_INDEX
`define PRIMITIVE_INDEX 8
`endif

package sphere_pkg;
    typedef logic signed [15:0] Fixed;
    typedef struct packed { Fixed x; Fixed y; Fixed z; } Vec3;
    typedef struct packed { Vec3 Orig; Vec3 Dir; } Ray;
    typedef struct packed { Vec3 Center; Fixed Radius; } Sphere;
    typedef struct packed { logic [7:0] R; logic [7:0] G; logic [7:0] B; } RGB8;
    typedef enum logic [1:0] {ST_None, ST_Diffuse, ST_Mirror, ST_Emissive} SurfaceType_t;
    typedef struct packed {
        logic                        bHit;
        Fixed                        T;
        logic [`PRIMITIVE_INDEX-1:0] PI;
        SurfaceType_t                SurfaceType;
        RGB8                         Color;
    } HitData;
endpackage

module sphere_closest_hit_scheduler
    import sphere_pkg::*;
#(
    parameter int unsigned NUM_SPHERES = 8,
    parameter int unsigned PI_WIDTH    = 8,
    parameter int unsigned HIT_LATENCY = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  Ray                  ray_in,
`ifdef SPHERE_ANY_HIT_EN
    input  logic                any_hit_mode,
`endif
    output logic                busy,
    output logic                done,
    output HitData              closest_hit,
    output logic [PI_WIDTH-1:0] sph_rd_addr,
    input  Sphere               sph_rd_data,
    input  RGB8                 sph_color,
    input  SurfaceType_t        sph_st,
    output logic                hit_req,
    output Ray                  hit_ray,
    output Sphere               hit_sphere,
    output RGB8                 hit_color,
    output SurfaceType_t        hit_st,
    output logic [PI_WIDTH-1:0] hit_pi,
    input  logic                hit_valid,
    input  HitData              hit_data
);

    if (NUM_SPHERES < 1 || HIT_LATENCY < 1) begin : g_param_check
        $error("sphere_closest_hit_scheduler: NUM_SPHERES and HIT_LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [PI_WIDTH-1:0] LAST_IDX = PI_WIDTH'(NUM_SPHERES - 1);
    localparam HitData              BEST_RST = '0;

    state_t              state_q, state_d;
    logic [PI_WIDTH-1:0] issue_idx_q, issue_idx_d;
    logic [PI_WIDTH-1:0] hit_pi_q, hit_pi_d;
    logic                hit_req_q, hit_req_d;
    logic [PI_WIDTH:0]   resp_cnt_q, resp_cnt_d, resp_target;
    Ray                  ray_q, ray_d;
    HitData              best_q, best_d;
    logic                collecting, candidate, better, replace, stop_issue;

`ifdef SPHERE_ANY_HIT_EN
    logic              any_q, any_d;
    logic              stopped_q, stopped_d;
    logic [PI_WIDTH:0] issued_q, issued_d;
`endif

    assign collecting = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    // Negative T means the hit lies behind the ray origin.
    assign candidate  = collecting && hit_valid && hit_data.bHit && !hit_data.T[15];
    assign better     = !best_q.bHit || ($signed(hit_data.T) < $signed(best_q.T));

`ifdef SPHERE_ANY_HIT_EN
    assign replace     = candidate && better && !stopped_q;
    assign stop_issue  = any_q && (candidate || stopped_q);
    assign resp_target = issued_d;
`else
    assign replace     = candidate && better;
    assign stop_issue  = 1'b0;
    assign resp_target = (PI_WIDTH+1)'(NUM_SPHERES);
`endif

    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        hit_pi_d    = hit_pi_q;
        hit_req_d   = 1'b0;
        ray_d       = ray_q;
        best_d      = replace ? hit_data : best_q;
        resp_cnt_d  = (collecting && hit_valid) ? resp_cnt_q + 1'b1 : resp_cnt_q;
`ifdef SPHERE_ANY_HIT_EN
        any_d       = any_q;
        stopped_d   = stopped_q || (any_q && candidate);
        issued_d    = issued_q + {{PI_WIDTH{1'b0}}, hit_req_q};
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ray_d       = ray_in;
                    best_d      = BEST_RST;
                    resp_cnt_d  = '0;
                    issue_idx_d = '0;
                    state_d     = S_ISSUE;
`ifdef SPHERE_ANY_HIT_EN
                    any_d       = any_hit_mode;
                    stopped_d   = 1'b0;
                    issued_d    = '0;
`endif
                end
            end
            S_ISSUE: begin
                // Table data for this address arrives next cycle, so the strobe is the delayed copy.
                if (!stop_issue) begin
                    hit_req_d = 1'b1;
                    hit_pi_d  = issue_idx_q;
                end
                if (stop_issue || issue_idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else begin
                    issue_idx_d = issue_idx_q + PI_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (resp_cnt_d == resp_target) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            issue_idx_q <= '0;
            hit_pi_q    <= '0;
            hit_req_q   <= 1'b0;
            resp_cnt_q  <= '0;
            ray_q       <= '0;
            best_q      <= BEST_RST;
`ifdef SPHERE_ANY_HIT_EN
            any_q       <= 1'b0;
            stopped_q   <= 1'b0;
            issued_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            issue_idx_q <= issue_idx_d;
            hit_pi_q    <= hit_pi_d;
            hit_req_q   <= hit_req_d;
            resp_cnt_q  <= resp_cnt_d;
            ray_q       <= ray_d;
            best_q      <= best_d;
`ifdef SPHERE_ANY_HIT_EN
            any_q       <= any_d;
            stopped_q   <= stopped_d;
            issued_q    <= issued_d;
`endif
        end
    end

    assign busy        = collecting;
    assign done        = (state_q == S_DONE);
    assign closest_hit = best_q;
    assign sph_rd_addr = issue_idx_q;
    assign hit_req     = hit_req_q;
    assign hit_pi      = hit_pi_q;
    assign hit_ray     = ray_q;
    assign hit_sphere  = sph_rd_data;
    assign hit_color   = sph_color;
    assign hit_st      = sph_st;

endmodule

// File: doc/sphere_closest_hit_scheduler.md
Name: sphere_closest_hit_scheduler

Overview:
- Initiator side of the sphere hit interface: takes one ray, walks the sphere table, and issues each sphere to a sphere-hit unit.
- Collects that unit's HitData responses and resolves the closest valid hit.
- Sits between the ray generator/shader front end and the per-primitive hit units; returns one HitData per ray with a done pulse.

Parameters:
- NUM_SPHERES, 8: sphere table entries scanned per ray; must be >= 1.
- PI_WIDTH, 8: width of the primitive index (matches `PRIMITIVE_INDEX).
- HIT_LATENCY, 1: cycles from hit_req to the matching hit_valid in the hit unit; must be >= 1.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  ray request; sampled only in IDLE
- ray_in  in  Ray  ray to test; latched when start is accepted
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when closest_hit is final
- closest_hit  out  HitData  resolved result; held until next accepted start
- sph_rd_addr  out  PI_WIDTH  sphere table read address
- sph_rd_data  in  Sphere  table data, valid one cycle after sph_rd_addr
- sph_color  in  RGB8  table colour, same timing as sph_rd_data
- sph_st  in  SurfaceType  table surface type, same timing as sph_rd_data
- hit_req  out  1  issue strobe to hit unit
- hit_ray  out  Ray  latched ray, constant while busy
- hit_sphere  out  Sphere  sphere under test
- hit_color  out  RGB8  colour of sphere under test
- hit_st  out  SurfaceType  surface type of sphere under test
- hit_pi  out  PI_WIDTH  index of sphere under test
- hit_valid  in  1  response strobe from hit unit
- hit_data  in  HitData  response payload

Behaviour:
- Reset values: busy=0, done=0, hit_req=0, sph_rd_addr=0, hit_pi=0, closest_hit.bHit=0, closest_hit.T=0, closest_hit.SurfaceType=ST_None, state=IDLE, all counters=0.
- Reset asserted mid-ray aborts immediately. Responses still in flight after resetn rises are ignored, because hit_valid is only counted in ISSUE/DRAIN.

FSM:
- IDLE: start=1 latches ray_in, clears best to the reset value, sets busy, goes to ISSUE. start while busy is ignored.
- ISSUE: sph_rd_addr = issue_idx, counting 0..NUM_SPHERES-1, one per cycle. A one-cycle-delayed copy drives hit_req=1 with hit_sphere/hit_color/hit_st from the table and hit_pi = delayed index. After the last address, go to DRAIN.
- DRAIN: issue completes on the next cycle. Wait until resp_cnt reaches NUM_SPHERES, then go to DONE.
- DONE: closest_hit is registered, done=1 for one cycle, busy=0, go to IDLE.

Timing and response handling:
- Start accepted at cycle 0 → sph_rd_addr valid cycles 1..N, hit_req cycles 2..N+1, done at cycle N+HIT_LATENCY+2 (N = NUM_SPHERES).
- Responses are counted only while busy. hit_valid arrives in issue order; no backpressure.
- resp_cnt is PI_WIDTH+1 bits so N = 2^PI_WIDTH does not wrap.

Resolution, applied to each hit_valid:
- Candidate if hit_data.bHit=1 and T sign bit = 0 (T >= 0).
- Replaces best if best.bHit=0 or candidate T < best.T (signed Fixed compare).
- Equal T keeps the earlier (lower PI) entry.
- Non-candidates are discarded.
- All HitData fields of the winner are copied unchanged.

Boundaries:
- N=1: done at cycle HIT_LATENCY+3.
- No hits: closest_hit equals its reset value.
- hit_valid while not busy: ignored.

Optional Feature:
- Macro SPHERE_ANY_HIT_EN.
- Defined: adds input any_hit_mode (latched with start). When latched high, the first candidate stops further issue (issue_idx frozen, hit_req=0 from the next cycle). Already-issued responses drain and are counted but do not replace best. done pulses once resp_cnt equals the number issued. Used for shadow rays.
- Not defined: port absent; every ray scans all NUM_SPHERES.

Test Plan:
- N=4, HIT_LATENCY=1, hit unit returns T={5,2,7,3}, all bHit=1 → closest_hit.PI=1, T=2; done pulses at cycle 7 after start.
- All bHit=0 → closest_hit.bHit=0, SurfaceType=ST_None, done at cycle 7; busy high cycles 1..6.
- T={4,4,-1,9}, all bHit=1 → PI=0 (tie keeps earlier), T=4; the negative-T hit is rejected.
- start pulsed again at cycle 3 during a ray → ignored; exactly one done; then a new start yields a fresh result with no leftover best.
- resetn low at cycle 4 of a scan → all outputs at reset values asynchronously; a late hit_valid is ignored; the next ray's result is correct.
- SPHERE_ANY_HIT_EN, any_hit_mode=1, hit on PI=1 with HIT_LATENCY=1 → hit_req stops after PI=2 is issued; closest_hit.PI=1; done asserted before the full-scan cycle count.
